// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - game score keeper: frame-tick and bonus scoring with BCD digits and hi-score
module score_keeper #(
    parameter int TICK_DIV = 6,
    parameter int BONUS    = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        collide,
    input  logic        bonus,
    output logic [13:0] score,
    output logic [3:0]  digit0,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic [3:0]  digit3,
    output logic [13:0] hi_score,
    output logic        running,
    output logic        game_over
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_RUN     = 2'd1;
    localparam logic [1:0]  S_OVER    = 2'd2;
    localparam logic [5:0]  DIV_LAST  = 6'(TICK_DIV - 1);
    localparam logic [8:0]  BONUS_W   = 9'(BONUS);
    localparam logic [13:0] SCORE_MAX = 14'd9999;

    logic [1:0]       state_q, state_d;
    logic [13:0]      score_q, score_d;
    logic [3:0][3:0]  dig_q, dig_d;
    logic [13:0]      hi_q, hi_d;
    logic [5:0]       div_q, div_d;
    logic [7:0]       pend_q, pend_d;
    logic             running_q, running_d;
    logic             over_q, over_d;

    logic [3:0][3:0]  dig_inc;
    logic             bcd_carry;
    logic             tick;
    logic             drain;
    logic [8:0]       pend_sum;

    // Ripple BCD increment; the score saturates before thousands can overflow.
    always_comb begin
        dig_inc   = dig_q;
        bcd_carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bcd_carry) begin
                if (dig_q[i] == 4'd9) begin
                    dig_inc[i] = 4'd0;
                end else begin
                    dig_inc[i] = dig_q[i] + 4'd1;
                    bcd_carry  = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        dig_d    = dig_q;
        hi_d     = hi_q;
        div_d    = div_q;
        pend_d   = pend_q;
        tick     = frame_tick && (div_q == DIV_LAST);
        drain    = !tick && (pend_q != 8'd0);
        pend_sum = {1'b0, pend_q} - {8'd0, drain} + (bonus ? BONUS_W : 9'd0);

        case (state_q)
            S_RUN: begin
                if (collide) begin
                    state_d = S_OVER;
                    pend_d  = 8'd0;
                    if (score_q > hi_q) begin
                        hi_d = score_q;
                    end
                end else begin
                    if (frame_tick) begin
                        div_d = tick ? 6'd0 : div_q + 6'd1;
                    end
                    pend_d = (pend_sum > 9'd255) ? 8'd255 : pend_sum[7:0];
                    // A tick preempts the drain for this cycle; pending is left for the next.
                    if ((tick || drain) && (score_q != SCORE_MAX)) begin
                        score_d = score_q + 14'd1;
                        dig_d   = dig_inc;
                    end
                end
            end
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d = S_RUN;
                    score_d = 14'd0;
                    dig_d   = '0;
                    div_d   = 6'd0;
                    pend_d  = 8'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        running_d = (state_d == S_RUN);
        over_d    = (state_d == S_OVER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            score_q   <= 14'd0;
            dig_q     <= '0;
            hi_q      <= 14'd0;
            div_q     <= 6'd0;
            pend_q    <= 8'd0;
            running_q <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            dig_q     <= dig_d;
            hi_q      <= hi_d;
            div_q     <= div_d;
            pend_q    <= pend_d;
            running_q <= running_d;
            over_q    <= over_d;
        end
    end

    assign score     = score_q;
    assign digit0    = dig_q[0];
    assign digit1    = dig_q[1];
    assign digit2    = dig_q[2];
    assign digit3    = dig_q[3];
    assign hi_score  = hi_q;
    assign running   = running_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - directed self-checking bench for score_keeper
module tb_score_keeper;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic        collide = 1'b0;
    logic        bonus = 1'b0;
    logic [13:0] score;
    logic [3:0]  digit0, digit1, digit2, digit3;
    logic [13:0] hi_score;
    logic        running, game_over;

    int checks = 0;
    int errors = 0;

    score_keeper #(.TICK_DIV(6), .BONUS(50)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .collide(collide), .bonus(bonus), .score(score),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .hi_score(hi_score), .running(running), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Drive inputs for one rising edge; returns at the following falling edge.
    task automatic step(input logic ft, input logic st, input logic co, input logic bo);
        frame_tick = ft; start = st; collide = co; bonus = bo;
        @(negedge clk);
        frame_tick = 1'b0; start = 1'b0; collide = 1'b0; bonus = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1, 0, 0, 0);
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({score, hi_score, digit3, digit2, digit1, digit0, running, game_over} !== 46'd0) begin
            errors++;
            $display("FAIL reset_during: score=%0d hi=%0d run=%b over=%b, required all 0", score, hi_score, running, game_over);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({score, hi_score, running, game_over} !== 30'd0) begin
            errors++;
            $display("FAIL reset_after: score=%0d hi=%0d run=%b over=%b, required all 0", score, hi_score, running, game_over);
        end
    endtask

    task automatic test_ticks;
        step(0, 1, 0, 0);
        ticks(18);
        checks++;
        if (score !== 14'd3 || {digit3, digit2, digit1, digit0} !== 16'h0003 || running !== 1'b1) begin
            errors++;
            $display("FAIL ticks_18: score=%0d digits=%h run=%b, required 3 0003 1", score, {digit3, digit2, digit1, digit0}, running);
        end
    endtask

    task automatic test_bonus_drain;
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        checks++;
        if (score !== 14'd0) begin
            errors++;
            $display("FAIL bonus_edge: score=%0d, required 0", score);
        end
        idle(25);
        checks++;
        if (score !== 14'd25) begin
            errors++;
            $display("FAIL bonus_mid: score=%0d, required 25", score);
        end
        idle(25);
        idle(5);
        checks++;
        if (score !== 14'd50 || {digit3, digit2, digit1, digit0} !== 16'h0050) begin
            errors++;
            $display("FAIL bonus_done: score=%0d digits=%h, required 50 0050", score, {digit3, digit2, digit1, digit0});
        end
    endtask

    task automatic test_carry;
        ticks(299);
        checks++;
        if (score !== 14'd99 || {digit3, digit2, digit1, digit0} !== 16'h0099) begin
            errors++;
            $display("FAIL carry_99: score=%0d digits=%h, required 99 0099", score, {digit3, digit2, digit1, digit0});
        end
        ticks(1);
        checks++;
        if (score !== 14'd100 || {digit3, digit2, digit1, digit0} !== 16'h0100) begin
            errors++;
            $display("FAIL carry_100: score=%0d digits=%h, required 100 0100", score, {digit3, digit2, digit1, digit0});
        end
    endtask

    task automatic test_tick_priority;
        step(0, 0, 0, 1);
        ticks(6);
        checks++;
        if (score !== 14'd106) begin
            errors++;
            $display("FAIL prio_ticks: score=%0d, required 106", score);
        end
        idle(50);
        checks++;
        if (score !== 14'd151 || {digit3, digit2, digit1, digit0} !== 16'h0151) begin
            errors++;
            $display("FAIL prio_drain: score=%0d digits=%h, required 151 0151", score, {digit3, digit2, digit1, digit0});
        end
    endtask

    task automatic test_back_to_back;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        checks++;
        if (score !== 14'd152) begin
            errors++;
            $display("FAIL b2b_bonus: score=%0d, required 152", score);
        end
        idle(102);
        checks++;
        if (score !== 14'd251) begin
            errors++;
            $display("FAIL b2b_drain: score=%0d, required 251", score);
        end
        repeat (6) step(0, 0, 0, 1);
        checks++;
        if (score !== 14'd256) begin
            errors++;
            $display("FAIL pend_sat_run: score=%0d, required 256", score);
        end
        idle(270);
        checks++;
        if (score !== 14'd511 || {digit3, digit2, digit1, digit0} !== 16'h0511) begin
            errors++;
            $display("FAIL pend_sat: score=%0d digits=%h, required 511 0511", score, {digit3, digit2, digit1, digit0});
        end
    endtask

    task automatic test_saturate;
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        repeat (198) begin
            step(0, 0, 0, 1);
            idle(49);
        end
        idle(60);
        checks++;
        if (score !== 14'd9900) begin
            errors++;
            $display("FAIL sat_9900: score=%0d, required 9900", score);
        end
        ticks(318);
        step(0, 0, 0, 1);
        idle(45);
        checks++;
        if (score !== 14'd9998 || {digit3, digit2, digit1, digit0} !== 16'h9998) begin
            errors++;
            $display("FAIL sat_9998: score=%0d digits=%h, required 9998 9998", score, {digit3, digit2, digit1, digit0});
        end
        idle(10);
        ticks(6);
        checks++;
        if (score !== 14'd9999 || {digit3, digit2, digit1, digit0} !== 16'h9999) begin
            errors++;
            $display("FAIL sat_9999: score=%0d digits=%h, required 9999 9999", score, {digit3, digit2, digit1, digit0});
        end
    endtask

    task automatic test_reset_mid;
        step(0, 0, 1, 0);
        checks++;
        if (hi_score !== 14'd9999 || game_over !== 1'b1) begin
            errors++;
            $display("FAIL mid_hi: hi=%0d over=%b, required 9999 1", hi_score, game_over);
        end
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        idle(60);
        ticks(258);
        step(0, 0, 0, 1);
        idle(30);
        checks++;
        if (score !== 14'd123 || {digit3, digit2, digit1, digit0} !== 16'h0123) begin
            errors++;
            $display("FAIL mid_123: score=%0d digits=%h, required 123 0123", score, {digit3, digit2, digit1, digit0});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({score, hi_score, digit3, digit2, digit1, digit0, running, game_over} !== 46'd0) begin
            errors++;
            $display("FAIL mid_async: score=%0d hi=%0d run=%b, required all 0 before clock", score, hi_score, running);
        end
        @(negedge clk);
        reset = 1'b0;
        step(0, 1, 0, 0);
        checks++;
        if (running !== 1'b1 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL mid_start: run=%b over=%b, required 1 0", running, game_over);
        end
        idle(10);
        ticks(5);
        checks++;
        if (score !== 14'd0 || hi_score !== 14'd0) begin
            errors++;
            $display("FAIL mid_discard: score=%0d hi=%0d, required 0 0", score, hi_score);
        end
        ticks(1);
        checks++;
        if (score !== 14'd1) begin
            errors++;
            $display("FAIL mid_first_tick: score=%0d, required 1", score);
        end
    endtask

    task automatic test_collide;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        step(0, 1, 0, 0);
        ticks(180);
        step(0, 0, 1, 0);
        checks++;
        if (score !== 14'd30 || hi_score !== 14'd30 || game_over !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL col_30: score=%0d hi=%0d over=%b run=%b, required 30 30 1 0", score, hi_score, game_over, running);
        end
        step(0, 1, 0, 0);
        ticks(257);
        step(1, 0, 1, 0);
        checks++;
        if (score !== 14'd42 || hi_score !== 14'd42 || game_over !== 1'b1) begin
            errors++;
            $display("FAIL col_42: score=%0d hi=%0d over=%b, required 42 42 1", score, hi_score, game_over);
        end
        step(0, 0, 0, 1);
        ticks(6);
        step(0, 0, 1, 0);
        idle(60);
        checks++;
        if (score !== 14'd42 || game_over !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL over_ignore: score=%0d over=%b run=%b, required 42 1 0", score, game_over, running);
        end
        step(0, 1, 0, 0);
        checks++;
        if (score !== 14'd0 || hi_score !== 14'd42 || running !== 1'b1 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL restart: score=%0d hi=%0d run=%b over=%b, required 0 42 1 0", score, hi_score, running, game_over);
        end
        step(0, 1, 1, 0);
        checks++;
        if (game_over !== 1'b1 || running !== 1'b0 || hi_score !== 14'd42) begin
            errors++;
            $display("FAIL start_collide: over=%b run=%b hi=%0d, required 1 0 42", game_over, running, hi_score);
        end
    endtask

    initial begin
        test_reset;
        test_ticks;
        test_bonus_drain;
        test_carry;
        test_tick_priority;
        test_back_to_back;
        test_saturate;
        test_reset_mid;
        test_collide;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
